im_fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the SISC core. It owns the program counter and drives the address port of the instruction memory. The memory is combinational: 16-bit word address in, 32-bit instruction out. The block buffers fetched instructions, with their PCs, in a small prefetch queue and presents them to decode over a valid/ready handshake. It also handles branch redirect (flush) and a halt request from the control unit.

---
 rtl/im_fetch_pkg.sv | 24 ++
 rtl/im_fetch_fifo.sv | 89 ++++++++
 rtl/im_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_im_fetch_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/im_fetch_pkg.sv
// Shared types and defaults for the SISC instruction fetch sequencer.
// Optional performance counters are enabled with the IM_FETCH_PERF_EN macro.
package im_fetch_pkg;

    localparam int          DEF_DEPTH    = 4;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        S_WARM  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [15:0] pc;
    } fetch_entry_t;

    // Sequential word address; wraps FFFF -> 0000 silently.
    function automatic logic [15:0] pc_incr(input logic [15:0] pc);
        return pc + 16'h0001;
    endfunction

endpackage

// File: rtl/im_fetch_fifo.sv
// Prefetch queue of {instr, pc} entries with push, pop, flush and occupancy.
// Head outputs come straight from storage registers.
module im_fetch_fifo
    import im_fetch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head_data,
    output logic                     head_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t      mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              full_s;
    logic              empty_s;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});

    // Guard push/pop so occupancy can neither overflow nor underflow.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (flush) begin
            pop_ok_s  = 1'b0;
            push_ok_s = 1'b0;
        end else begin
            pop_ok_s  = pop & ~empty_s;
            push_ok_s = push & (~full_s | pop_ok_s);
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data  = mem_r[rd_ptr_r];
    assign head_valid = ~empty_s;
    assign full       = full_s;
    assign count      = count_r;

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction fetch sequencer: PC, warm/fetch/halt FSM, redirect, prefetch queue.
// Define IM_FETCH_PERF_EN to add the fetch_cnt / stall_cnt counters.
module im_fetch_ctrl
    import im_fetch_pkg::*;
#(
    parameter int          DEPTH    = DEF_DEPTH,
    parameter logic [15:0] RESET_PC = DEF_RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst_f,
    output logic [15:0]              im_addr,
    input  logic [31:0]              im_data,
    input  logic                     redirect,
    input  logic [15:0]              redirect_pc,
    input  logic                     halt,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [15:0]              instr_pc,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   q_count
`ifdef IM_FETCH_PERF_EN
    ,
    output logic [15:0]              fetch_cnt,
    output logic [15:0]              stall_cnt
`endif
);

    fetch_state_t  state_r;
    fetch_state_t  state_nxt_s;
    logic [15:0]   fetch_pc_r;
    logic [15:0]   pc_nxt_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          head_valid_s;
    fetch_entry_t  head_s;
    fetch_entry_t  push_entry_s;

    assign push_entry_s = '{instr: im_data, pc: fetch_pc_r};

    // Next state, push/pop qualification and next PC; redirect overrides all.
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        pc_nxt_s    = fetch_pc_r;
        if (redirect) begin
            pc_nxt_s    = redirect_pc;
            state_nxt_s = halt ? S_HALT : state_r;
        end else begin
            pop_s = head_valid_s & instr_ready;
            case (state_r)
                S_WARM: begin
                    state_nxt_s = halt ? S_HALT : S_FETCH;
                end
                S_FETCH: begin
                    if (halt) begin
                        state_nxt_s = S_HALT;
                    end else begin
                        state_nxt_s = S_FETCH;
                        push_s      = ~full_s | pop_s;
                    end
                end
                S_HALT: begin
                    state_nxt_s = halt ? S_HALT : S_FETCH;
                end
                default: begin
                    state_nxt_s = S_WARM;
                end
            endcase
            if (push_s) begin
                pc_nxt_s = pc_incr(fetch_pc_r);
            end else begin
                pc_nxt_s = fetch_pc_r;
            end
        end
    end

    // FSM state and fetch PC registers.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_r    <= S_WARM;
            fetch_pc_r <= RESET_PC;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= pc_nxt_s;
        end
    end

    im_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_f),
        .flush      (redirect),
        .push       (push_s),
        .push_data  (push_entry_s),
        .pop        (pop_s),
        .head_data  (head_s),
        .head_valid (head_valid_s),
        .full       (full_s),
        .count      (q_count)
    );

    assign im_addr     = fetch_pc_r;
    assign instr_valid = head_valid_s;
    assign instr       = head_s.instr;
    assign instr_pc    = head_s.pc;

`ifdef IM_FETCH_PERF_EN
    logic [15:0] fetch_cnt_r;
    logic [15:0] stall_cnt_r;

    // Push count and full-queue stall cycles; free-running, wrap silently.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            fetch_cnt_r <= 16'h0000;
            stall_cnt_r <= 16'h0000;
        end else begin
            if (push_s) begin
                fetch_cnt_r <= fetch_cnt_r + 16'h0001;
            end
            if ((state_r == S_FETCH) && full_s && !pop_s) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_r;
    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed self-checking bench for im_fetch_ctrl; memory word k holds A000_0000+k.
module tb_im_fetch_ctrl;

    logic        clk;
    logic        rst_f;
    logic [15:0] im_addr;
    logic [31:0] im_data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        instr_valid;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  q_count;
`ifdef IM_FETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    im_fetch_ctrl dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .im_addr     (im_addr),
        .im_data     (im_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .q_count     (q_count)
`ifdef IM_FETCH_PERF_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    assign im_data = 32'hA000_0000 + {16'h0000, im_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] wrap_pc [4];

    initial begin
        wrap_pc[0] = 16'hFFFE;
        wrap_pc[1] = 16'hFFFF;
        wrap_pc[2] = 16'h0000;
        wrap_pc[3] = 16'h0001;

        rst_f       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        instr_ready = 1'b1;
        #12;
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_pc", {16'd0, instr_pc}, 32'd0);
        check_eq("rst_count", {29'd0, q_count}, 32'd0);
        check_eq("rst_addr", {16'd0, im_addr}, 32'd0);

        // Streaming with ready held high
        @(negedge clk) rst_f = 1'b1;
        tick();
        check_eq("warm_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("warm_addr", {16'd0, im_addr}, 32'd0);
        tick();
        check_eq("first_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("first_pc", {16'd0, instr_pc}, 32'd0);
        check_eq("first_instr", instr, 32'hA000_0000);
        for (int i = 1; i < 5; i++) begin
            tick();
            check_eq("stream_pc", {16'd0, instr_pc}, i);
            check_eq("stream_instr", instr, 32'hA000_0000 + i);
            check_eq("stream_count", {29'd0, q_count}, 32'd1);
        end

        // Back-pressure fills the queue, then drain in order
        @(negedge clk) rst_f = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk) rst_f = 1'b1;
        repeat (10) tick();
        check_eq("bp_count", {29'd0, q_count}, 32'd4);
        check_eq("bp_addr", {16'd0, im_addr}, 32'h0004);
        check_eq("bp_head", {16'd0, instr_pc}, 32'd0);
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("drain_valid", {31'd0, instr_valid}, 32'd1);
            check_eq("drain_pc", {16'd0, instr_pc}, i);
            tick();
            check_eq("full_pushpop_count", {29'd0, q_count}, 32'd4);
        end
        check_eq("pre_redir_head", {16'd0, instr_pc}, 32'd5);

        // Redirect flushes pcs 5..8
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check_eq("redir_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("redir_count", {29'd0, q_count}, 32'd0);
        check_eq("redir_addr", {16'd0, im_addr}, 32'h0040);
        tick();
        check_eq("redir_first_pc", {16'd0, instr_pc}, 32'h0040);
        check_eq("redir_first_instr", instr, 32'hA000_0040);
        tick();
        check_eq("redir_second_pc", {16'd0, instr_pc}, 32'h0041);

        // Halt drains three queued entries, then resumes at frozen address
        instr_ready = 1'b0;
        repeat (2) tick();
        check_eq("halt_pre_count", {29'd0, q_count}, 32'd3);
        check_eq("halt_pre_addr", {16'd0, im_addr}, 32'h0044);
        halt        = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("halt_drain_pc", {16'd0, instr_pc}, 32'h0041 + i);
            tick();
        end
        check_eq("halt_empty", {31'd0, instr_valid}, 32'd0);
        check_eq("halt_addr", {16'd0, im_addr}, 32'h0044);
        tick();
        check_eq("halt_addr_held", {16'd0, im_addr}, 32'h0044);
        halt = 1'b0;
        tick();
        check_eq("resume_gap", {31'd0, instr_valid}, 32'd0);
        tick();
        check_eq("resume_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("resume_pc", {16'd0, instr_pc}, 32'h0044);

        // PC wraps through FFFF
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        check_eq("wrap_flush", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("wrap_pc", {16'd0, instr_pc}, {16'd0, wrap_pc[i]});
        end

        // Halt and redirect together: flush, load PC, stay halted
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check_eq("hr_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("hr_addr", {16'd0, im_addr}, 32'h0100);
        tick();
        check_eq("hr_still_halted", {31'd0, instr_valid}, 32'd0);
        check_eq("hr_addr_held", {16'd0, im_addr}, 32'h0100);
        halt = 1'b0;
        repeat (2) tick();
        check_eq("hr_resume_pc", {16'd0, instr_pc}, 32'h0100);

        // Asynchronous reset while full
        instr_ready = 1'b0;
        repeat (6) tick();
        check_eq("async_pre_count", {29'd0, q_count}, 32'd4);
        #2;
        rst_f = 1'b0;
        #1;
        check_eq("async_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("async_count", {29'd0, q_count}, 32'd0);
        check_eq("async_addr", {16'd0, im_addr}, 32'h0000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
